// File: rtl/clk2_mon_pkg.sv
// Shared FSM encoding and default parameters for the clk2 monitor.
package clk2_mon_pkg;

    localparam int unsigned DEF_EXP_HALF = 2;
    localparam int unsigned DEF_LOCK_N   = 4;
    localparam int unsigned DEF_TIMEOUT  = 8;
    localparam int unsigned DEF_CNT_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_TRACK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// Registers clk2 once and produces rise/fall edge indications.
//   clk, rst_n        : clock, async active-low reset
//   din               : sampled level (same clock domain, no synchronizer)
//   en                : gates the registered strobes
//   rise_c / fall_c   : combinational edge detect (din vs registered copy)
//   rise_pulse / fall_pulse : one-cycle registered strobes, the cycle after detection
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic en,
    output logic rise_c,
    output logic fall_c,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic din_q;

    assign rise_c = din & ~din_q;
    assign fall_c = ~din & din_q;

    // Previous-level register and gated strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            din_q      <= din;
            rise_pulse <= rise_c & en;
            fall_pulse <= fall_c & en;
        end
    end

endmodule

// File: rtl/clk2_monitor.sv
// Monitors a divided clock (clk2) for expected half-period, lock and stuck/error.
//   clk, rst_n            : clock, async active-low reset
//   clk2                  : divided clock, synchronous to clk
//   out_valid             : qualifies clk2
//   clr                   : synchronous return to IDLE, clears err
//   rise_pulse/fall_pulse : one-cycle strobes per clk2 edge (not in IDLE)
//   half_len / half_vld   : last measured half-period and its update strobe
//   locked / err          : high while in LOCKED / ERROR
//   edge_cnt              : rising edges counted in ARM->TRACK and TRACK/LOCKED
module clk2_monitor
    import clk2_mon_pkg::*;
#(
    parameter int unsigned EXP_HALF = DEF_EXP_HALF,
    parameter int unsigned LOCK_N   = DEF_LOCK_N,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk2,
    input  logic             out_valid,
    input  logic             clr,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_len,
    output logic             half_vld,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam logic [CNT_W-1:0] RUN_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_V   = CNT_W'(EXP_HALF);
    localparam logic [CNT_W-1:0] LOCK_V  = CNT_W'(LOCK_N);
    // Timeout fires in the cycle whose update would bring the run length to TIMEOUT
    localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             rise_c, fall_c, edge_c;
    logic [CNT_W-1:0] run_q, match_q;

    logic in_meas_c, active_c, measure_c, hit_c, tmo_c, lock_hit_c;
    logic ld_half_c, inc_edge_c, inc_match_c;

    edge_detect u_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (clk2),
        .en         (state_q != ST_IDLE),
        .rise_c     (rise_c),
        .fall_c     (fall_c),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    assign edge_c     = rise_c | fall_c;
    assign in_meas_c  = (state_q == ST_TRACK) || (state_q == ST_LOCKED);
    // clr and a dropped qualifier both override any measurement this cycle
    assign active_c   = out_valid & ~clr;
    assign measure_c  = in_meas_c & active_c & edge_c;
    assign hit_c      = (run_q == EXP_V);
    assign tmo_c      = in_meas_c & active_c & ~edge_c & (run_q >= TO_V);
    assign lock_hit_c = ((match_q + CNT_W'(1)) == LOCK_V);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (out_valid) state_d = ST_ARM;
                ST_ARM: begin
                    if (!out_valid)  state_d = ST_IDLE;
                    else if (rise_c) state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (!out_valid)                state_d = ST_IDLE;
                    else if (tmo_c)                state_d = ST_ERROR;
                    else if (measure_c && !hit_c)  state_d = ST_ERROR;
                    else if (measure_c && lock_hit_c) state_d = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (!out_valid)                      state_d = ST_IDLE;
                    else if (tmo_c || (measure_c && !hit_c)) state_d = ST_ERROR;
                end
                ST_ERROR:  state_d = ST_ERROR;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath control decode
    always_comb begin
        ld_half_c   = measure_c;
        inc_edge_c  = active_c & rise_c & ((state_q == ST_ARM) | in_meas_c);
        inc_match_c = measure_c & hit_c & (state_q == ST_TRACK);
    end

    // Run length, match count and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= '0;
            match_q  <= '0;
            edge_cnt <= '0;
            half_len <= '0;
            half_vld <= 1'b0;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) run_q <= '0;
            else if (edge_c)        run_q <= CNT_W'(1);
            else if (run_q != RUN_MAX) run_q <= run_q + CNT_W'(1);

            if (state_d != ST_TRACK) match_q <= '0;
            else if (inc_match_c)    match_q <= match_q + CNT_W'(1);

            if (state_d == ST_IDLE) edge_cnt <= '0;
            else if (inc_edge_c)    edge_cnt <= edge_cnt + CNT_W'(1);

            if (ld_half_c) half_len <= run_q;
            half_vld <= ld_half_c;
            locked   <= (state_d == ST_LOCKED);
            err      <= (state_d == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_clk2_monitor.sv
module tb_clk2_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk2 = 1'b0;
    logic       out_valid = 1'b0;
    logic       clr = 1'b0;

    logic       rise_pulse, fall_pulse, half_vld, locked, err;
    logic [7:0] half_len, edge_cnt;
    logic       b_rise, b_fall, b_half_vld, b_locked, b_err;
    logic [3:0] b_half_len, b_edge_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk2_monitor dut (
        .clk(clk), .rst_n(rst_n), .clk2(clk2), .out_valid(out_valid), .clr(clr),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .half_len(half_len),
        .half_vld(half_vld), .locked(locked), .err(err), .edge_cnt(edge_cnt)
    );

    clk2_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clk2(clk2), .out_valid(out_valid), .clr(clr),
        .rise_pulse(b_rise), .fall_pulse(b_fall), .half_len(b_half_len),
        .half_vld(b_half_vld), .locked(b_locked), .err(b_err), .edge_cnt(b_edge_cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v);
        clk2 = v;
        cyc();
    endtask

    // Arms from IDLE or ARM and locks with half-period 2; leaves clk2=1 held 2 cycles
    task automatic lock_seq(input string tag);
        logic lvl;
        drive(1'b0);
        drive(1'b0);
        drive(1'b1);
        checks++;
        if (rise_pulse !== 1'b1 || half_vld !== 1'b0 || edge_cnt !== 8'd1) begin
            failures++;
            $display("FAIL %s_arm_edge: rise=%b vld=%b cnt=%0d, need 1 0 1", tag, rise_pulse, half_vld, edge_cnt);
        end
        drive(1'b1);
        lvl = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            lvl = ~lvl;
            drive(lvl);
            checks++;
            if (half_vld !== 1'b1 || half_len !== 8'd2 || locked !== (k == 4) || err !== 1'b0) begin
                failures++;
                $display("FAIL %s_match%0d: vld=%b len=%0d locked=%b err=%b, need 1 2 %b 0",
                         tag, k, half_vld, half_len, locked, err, (k == 4));
            end
            drive(lvl);
        end
        checks++;
        if (edge_cnt !== 8'd3 || b_edge_cnt !== 4'd3 || b_locked !== 1'b1) begin
            failures++;
            $display("FAIL %s_locked_cnt: cnt=%0d cnt4=%0d locked4=%b, need 3 3 1", tag, edge_cnt, b_edge_cnt, b_locked);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({rise_pulse, fall_pulse, half_vld, locked, err} !== 5'b0 || half_len !== 8'd0 || edge_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: pulses/vld/lock/err=%b len=%0d cnt=%0d, need all 0",
                     {rise_pulse, fall_pulse, half_vld, locked, err}, half_len, edge_cnt);
        end
        #2 rst_n = 1'b1;
        out_valid = 1'b1;
    endtask

    task automatic test_lock();
        lock_seq("lock");
        // first measured edge after ARM is a falling edge
    endtask

    task automatic test_mismatch();
        drive(1'b0);
        drive(1'b0);
        drive(1'b1);
        drive(1'b1);
        drive(1'b1);
        drive(1'b0);
        checks++;
        if (half_vld !== 1'b1 || half_len !== 8'd3 || err !== 1'b1 || locked !== 1'b0 || fall_pulse !== 1'b1) begin
            failures++;
            $display("FAIL mismatch: vld=%b len=%0d err=%b locked=%b fall=%b, need 1 3 1 0 1",
                     half_vld, half_len, err, locked, fall_pulse);
        end
        drive(1'b0);
        drive(1'b1);
        checks++;
        if (err !== 1'b1 || half_vld !== 1'b0 || rise_pulse !== 1'b1 || edge_cnt !== 8'd4) begin
            failures++;
            $display("FAIL error_sticky: err=%b vld=%b rise=%b cnt=%0d, need 1 0 1 4", err, half_vld, rise_pulse, edge_cnt);
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        checks++;
        if (err !== 1'b0 || locked !== 1'b0 || edge_cnt !== 8'd0) begin
            failures++;
            $display("FAIL clr_error: err=%b locked=%b cnt=%0d, need 0 0 0", err, locked, edge_cnt);
        end
    endtask

    task automatic test_timeout();
        lock_seq("to");
        for (int j = 1; j <= 6; j++) begin
            drive(1'b1);
            checks++;
            if (err !== (j == 6) || locked !== (j != 6)) begin
                failures++;
                $display("FAIL timeout_hold%0d: err=%b locked=%b, need %b %b", j, err, locked, (j == 6), (j != 6));
            end
        end
        clr = 1'b1;
        drive(1'b0);
        clr = 1'b0;
        checks++;
        if (err !== 1'b0 || fall_pulse !== 1'b1 || edge_cnt !== 8'd0) begin
            failures++;
            $display("FAIL timeout_clr: err=%b fall=%b cnt=%0d, need 0 1 0", err, fall_pulse, edge_cnt);
        end
        // IDLE suppresses strobes
        drive(1'b1);
        checks++;
        if (rise_pulse !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_strobe: rise=%b err=%b, need 0 0", rise_pulse, err);
        end
    endtask

    task automatic test_clr_priority();
        lock_seq("clrp");
        drive(1'b1);
        clr = 1'b1;
        drive(1'b0);
        clr = 1'b0;
        checks++;
        if (err !== 1'b0 || half_vld !== 1'b0 || locked !== 1'b0 || edge_cnt !== 8'd0) begin
            failures++;
            $display("FAIL clr_priority: err=%b vld=%b locked=%b cnt=%0d, need 0 0 0 0", err, half_vld, locked, edge_cnt);
        end
    endtask

    task automatic test_valid_drop();
        lock_seq("vd");
        out_valid = 1'b0;
        drive(1'b0);
        out_valid = 1'b1;
        checks++;
        if (locked !== 1'b0 || edge_cnt !== 8'd0 || half_vld !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL valid_drop: locked=%b cnt=%0d vld=%b err=%b, need 0 0 0 0", locked, edge_cnt, half_vld, err);
        end
        lock_seq("relock");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 14; i++) begin
            drive(1'b0);
            drive(1'b0);
            drive(1'b1);
            drive(1'b1);
        end
        checks++;
        if (edge_cnt !== 8'd17 || b_edge_cnt !== 4'd1 || err !== 1'b0 || b_err !== 1'b0 || b_locked !== 1'b1) begin
            failures++;
            $display("FAIL wrap: cnt=%0d cnt4=%0d err=%b err4=%b locked4=%b, need 17 1 0 0 1",
                     edge_cnt, b_edge_cnt, err, b_err, b_locked);
        end
    endtask

    task automatic test_reset_mid();
        out_valid = 1'b0;
        drive(1'b0);
        out_valid = 1'b1;
        drive(1'b0);
        drive(1'b1);
        drive(1'b1);
        drive(1'b0);
        checks++;
        if (half_vld !== 1'b1 || fall_pulse !== 1'b1 || edge_cnt !== 8'd1) begin
            failures++;
            $display("FAIL pre_reset_track: vld=%b fall=%b cnt=%0d, need 1 1 1", half_vld, fall_pulse, edge_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rise_pulse, fall_pulse, half_vld, locked, err} !== 5'b0 || half_len !== 8'd0 || edge_cnt !== 8'd0 ||
            b_half_len !== 4'd0 || b_half_vld !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: flags=%b len=%0d cnt=%0d len4=%0d, need 0 0 0 0",
                     {rise_pulse, fall_pulse, half_vld, locked, err}, half_len, edge_cnt, b_half_len);
        end
        rst_n = 1'b1;
        lock_seq("post_rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lock();
        test_mismatch();
        test_timeout();
        test_clr_priority();
        test_valid_drop();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk2_monitor.md
CLK2_MONITOR -- requirements
Module: clk2_monitor

Interface
REQ-001 Parameter EXP_HALF, default 2, expected clk2 half-period in clk cycles.
REQ-002 Parameter LOCK_N, default 4, consecutive matching half-periods required to declare lock.
REQ-003 Parameter TIMEOUT, default 8, clk cycles without a clk2 edge that count as a stuck clock.
REQ-004 Parameter CNT_W, default 8, width of half_len, edge_cnt and internal counters.
REQ-005 Port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port clk2, input, 1, divided clock from the upstream counter, synchronous to clk.
REQ-008 Port out_valid, input, 1, upstream qualifier; clk2 is meaningful only while high.
REQ-009 Port clr, input, 1, synchronous clear of err and return to IDLE.
REQ-010 Port rise_pulse / fall_pulse, output, 1 each, one-cycle strobe per detected clk2 rising / falling edge.
REQ-011 Port half_len, output, CNT_W, last measured half-period in clk cycles.
REQ-012 Port half_vld, output, 1, one-cycle strobe when half_len updates.
REQ-013 Port locked, output, 1, high while in LOCKED.
REQ-014 Port err, output, 1, sticky error flag, high while in ERROR.
REQ-015 Port edge_cnt, output, CNT_W, count of rising edges seen in TRACK/LOCKED, wraps at 2^CNT_W.

Function
REQ-016 clk2 SHALL be registered once (clk2_q); edge = clk2 != clk2_q; no synchronizer, same clock domain.
REQ-017 rise_pulse/fall_pulse SHALL be registered: high exactly one cycle, the cycle after the edge is detected.
REQ-018 Run-length counter SHALL count cycles clk2 holds its level; on an edge it loads 1; it saturates at 2^CNT_W-1.
REQ-019 On each edge in TRACK/LOCKED, half_len SHALL load the run length of the previous level and half_vld SHALL pulse in the same cycle as the edge strobe.
REQ-020 FSM states: IDLE, ARM, TRACK, LOCKED, ERROR; encoding from the shared package.
REQ-021 IDLE -> ARM when out_valid=1.
REQ-022 ARM -> TRACK on first clk2 rising edge; that edge increments edge_cnt but produces no half_len (no measurement).
REQ-023 TRACK: matching half-period (== EXP_HALF) increments match count; at LOCK_N matches -> LOCKED; mismatch -> ERROR.
REQ-024 LOCKED: any mismatching half-period -> ERROR; matches keep LOCKED.
REQ-025 TRACK/LOCKED: run length reaching TIMEOUT without an edge -> ERROR.
REQ-026 out_valid=0 in ARM/TRACK/LOCKED -> IDLE next cycle, match count cleared; ERROR ignores out_valid.
REQ-027 ERROR is sticky; leaves only via clr (-> IDLE) or reset.
REQ-028 clr=1 in any state -> IDLE next cycle; clr takes priority over edge, mismatch and timeout in the same cycle.
REQ-029 edge_cnt SHALL clear on entry to IDLE and wrap modulo 2^CNT_W without error.
REQ-030 Edge strobes SHALL continue in all states except IDLE; half_len holds its value outside TRACK/LOCKED.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, clk2_q=0, counters 0, and all outputs 0.
REQ-032 Reset asserted mid-measurement SHALL discard the partial run; after release the FSM re-arms from IDLE.

Structure
REQ-033 Package clk2_mon_pkg SHALL hold the FSM state typedef and default EXP_HALF, LOCK_N, TIMEOUT, CNT_W constants.
REQ-034 One sub-module, edge_detect (clk2_q register plus rise/fall strobes), SHALL be instantiated; all other logic stays in clk2_monitor.

Verification
REQ-035 Reset released, out_valid=1, clk2 toggles every 2 cycles -> half_len=2 per edge; locked=1 after the 4th matching half-period; err=0.
REQ-036 Locked, then one clk2 high phase lasts 3 cycles -> half_vld with half_len=3, err=1, locked=0 next cycle.
REQ-037 Locked, clk2 held constant for 8 cycles -> err=1 at timeout; clr pulse -> state IDLE, err=0.
REQ-038 Locked, out_valid dropped for 1 cycle -> IDLE, edge_cnt=0, locked=0; re-arms and relocks after 4 more matches.
REQ-039 CNT_W=4, 17 rising edges in LOCKED -> edge_cnt wraps to 1 (counting the ARM edge), no err.
REQ-040 rst_n pulsed low mid-TRACK -> all outputs 0 immediately, independent of clk.
